// File: rtl/resp_arb_pkg.sv
// Shared response definitions: response type codes, arbiter state encodings,
// response string lengths and the latched response payload type.
package resp_arb_pkg;

    // Response type codes as carried on req_type / send_resp_type.
    // Code 2'b10 is reserved and is treated as DATA by resp_gen.
    localparam logic [1:0] RESP_OK   = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b01;
    localparam logic [1:0] RESP_RSVD = 2'b10;
    localparam logic [1:0] RESP_DATA = 2'b11;

    // Arbiter state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Character counts of the strings resp_gen emits for each response type.
    localparam int STR_OK_LEN   = 2;   // "OK"
    localparam int STR_ERR_LEN  = 3;   // "ERR"
    localparam int STR_DATA_LEN = 4;   // four hex digits

    // Payload captured from the winning requester at grant time.
    typedef struct packed {
        logic [1:0]  typ;
        logic [15:0] data;
    } resp_t;

    // Bits needed to index n items; never less than 1.
    function automatic int clogb2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/resp_arb_rr_pick.sv
// Round-robin winner selection: scans the request vector starting at ptr,
// wrapping past the top, and reports the first asserted request.
module rr_pick
    import resp_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int REQ_WID = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [REQ_WID-1:0] ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [REQ_WID-1:0] win_idx,
    output logic               any
);

    logic [REQ_WID-1:0] sel;

    // First requester at or after ptr (modulo NUM_REQ) wins.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        sel     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel = REQ_WID'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[sel]) begin
                any          = 1'b1;
                win_oh[sel]  = 1'b1;
                win_idx      = sel;
            end
        end
    end

endmodule

// File: rtl/resp_arb.sv
// Shares resp_gen between NUM_REQ requesters. A round-robin winner's payload
// is latched and offered to resp_gen until its done pulse, which is routed
// back to that requester only. A one-cycle HOLD after each response makes
// sure resp_gen sees val low before the next request.
module resp_arb
    import resp_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                  clk_rx,
    input  logic                  rst_clk_rx_n,
    input  logic [NUM_REQ-1:0]    req_val,
    input  logic [2*NUM_REQ-1:0]  req_type,
    input  logic [16*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_done,
    output logic                  send_resp_val,
    output logic [1:0]            send_resp_type,
    output logic [15:0]           send_resp_data,
    input  logic                  send_resp_done,
    output logic                  arb_busy,
    output logic [NUM_REQ-1:0]    arb_grant
);

    localparam int REQ_WID = clogb2(NUM_REQ);

    logic [1:0]         state;
    logic [REQ_WID-1:0] rr_ptr;
    resp_t              resp_q;
    resp_t              sel_resp;
    logic [NUM_REQ-1:0] pick_oh;
    logic [REQ_WID-1:0] pick_idx;
    logic               pick_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .REQ_WID (REQ_WID)
    ) u_rr_pick (
        .req     (req_val),
        .ptr     (rr_ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // Mux out the payload slice belonging to the current round-robin winner.
    always_comb begin
        sel_resp = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                sel_resp.typ  = req_type[2*i +: 2];
                sel_resp.data = req_data[16*i +: 16];
            end
        end
    end

    assign send_resp_type = resp_q.typ;
    assign send_resp_data = resp_q.data;
    assign arb_busy       = (state != ST_IDLE);

    // Grant / wait-for-done / one-cycle hold sequencing with payload latch.
    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            resp_q        <= '0;
            send_resp_val <= 1'b0;
            req_done      <= '0;
            arb_grant     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_done <= '0;
                    if (pick_any) begin
                        resp_q        <= sel_resp;
                        send_resp_val <= 1'b1;
                        arb_grant     <= pick_oh;
                        rr_ptr        <= (pick_idx == REQ_WID'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        state         <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (send_resp_done) begin
                        send_resp_val <= 1'b0;
                        req_done      <= arb_grant;
                        arb_grant     <= '0;
                        state         <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    req_done <= '0;
                    state    <= ST_IDLE;
                end
                default: begin
                    send_resp_val <= 1'b0;
                    req_done      <= '0;
                    arb_grant     <= '0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resp_arb.sv
// Bench for resp_arb with three requesters: directed scenarios with literal
// expectations, then randomized requesters and a randomized resp_gen stand-in,
// all compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_resp_arb;

    localparam int N = 3;

    logic           clk_rx;
    logic           rst_clk_rx_n;
    logic [N-1:0]   req_val;
    logic [2*N-1:0] req_type;
    logic [16*N-1:0] req_data;
    logic [N-1:0]   req_done;
    logic           send_resp_val;
    logic [1:0]     send_resp_type;
    logic [15:0]    send_resp_data;
    logic           send_resp_done;
    logic           arb_busy;
    logic [N-1:0]   arb_grant;

    int n_tests = 0;
    int n_fail  = 0;

    resp_arb #(.NUM_REQ(N)) dut (
        .clk_rx         (clk_rx),
        .rst_clk_rx_n   (rst_clk_rx_n),
        .req_val        (req_val),
        .req_type       (req_type),
        .req_data       (req_data),
        .req_done       (req_done),
        .send_resp_val  (send_resp_val),
        .send_resp_type (send_resp_type),
        .send_resp_data (send_resp_data),
        .send_resp_done (send_resp_done),
        .arb_busy       (arb_busy),
        .arb_grant      (arb_grant)
    );

    initial clk_rx = 1'b0;
    always #5 clk_rx = ~clk_rx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // m_owner: index of the requester currently being served, -1 if none.
    // m_hold : set for the single quiet cycle after a completed response.
    int          m_ptr   = 0;
    int          m_owner = -1;
    int          m_hold  = 0;
    logic [1:0]  m_type  = 2'b00;
    logic [15:0] m_data  = 16'h0;
    logic [N-1:0] m_done = '0;

    // Advance the model on each clock edge from the inputs seen at that edge.
    always @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            m_ptr = 0; m_owner = -1; m_hold = 0;
            m_type = 2'b00; m_data = 16'h0; m_done = '0;
        end else if (m_hold != 0) begin
            m_hold = 0;
            m_done = '0;
        end else if (m_owner >= 0) begin
            if (send_resp_done) begin
                m_done = '0;
                m_done[m_owner] = 1'b1;
                m_owner = -1;
                m_hold  = 1;
            end
        end else begin
            m_done = '0;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (m_owner < 0 && req_val[i]) begin
                    m_owner = i;
                    m_type  = req_type[2*i +: 2];
                    m_data  = req_data[16*i +: 16];
                    m_ptr   = (i + 1) % N;
                end
            end
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk_rx) begin
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check("mdl_val",   32'(send_resp_val), 32'(m_owner >= 0));
        check("mdl_grant", 32'(arb_grant),     32'(eg));
        check("mdl_busy",  32'(arb_busy),      32'((m_owner >= 0) || (m_hold != 0)));
        check("mdl_done",  32'(req_done),      32'(m_done));
        if (m_owner >= 0) begin
            check("mdl_type", 32'(send_resp_type), 32'(m_type));
            check("mdl_data", 32'(send_resp_data), 32'(m_data));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_rx);
        #1;
    endtask

    task automatic wait_val();
        for (int c = 0; c < 40 && !send_resp_val; c++) tick();
        check("val_wait", 32'(send_resp_val), 32'd1);
    endtask

    // Wait for a grant, return done dly cycles later, check routing.
    task automatic serve(input logic [N-1:0] exp_g, input int dly, input bit drop);
        wait_val();
        check("grant", 32'(arb_grant), 32'(exp_g));
        repeat (dly) tick();
        send_resp_done = 1'b1;
        tick();
        send_resp_done = 1'b0;
        check("req_done", 32'(req_done), 32'(exp_g));
        check("val_low",  32'(send_resp_val), 32'd0);
        if (drop) req_val = req_val & ~exp_g;
    endtask

    task automatic do_reset();
        rst_clk_rx_n = 1'b0;
        tick();
        rst_clk_rx_n = 1'b1;
    endtask

    initial begin
        int lat, cnt;
        req_val = '0; req_type = '0; req_data = '0; send_resp_done = 1'b0;
        rst_clk_rx_n = 1'b1;
        #1 rst_clk_rx_n = 1'b0;
        repeat (2) tick();
        check("rst_val",   32'(send_resp_val), 32'd0);
        check("rst_busy",  32'(arb_busy),      32'd0);
        check("rst_grant", 32'(arb_grant),     32'd0);
        check("rst_done",  32'(req_done),      32'd0);
        rst_clk_rx_n = 1'b1;
        tick();

        // Single request from requester 0, DATA type.
        req_type[1:0] = 2'b11; req_data[15:0] = 16'h1234; req_val = 3'b001;
        tick();
        check("t2_val",   32'(send_resp_val),  32'd1);
        check("t2_type",  32'(send_resp_type), 32'h3);
        check("t2_data",  32'(send_resp_data), 32'h1234);
        check("t2_grant", 32'(arb_grant),      32'b001);
        repeat (3) tick();
        send_resp_done = 1'b1;
        tick();
        send_resp_done = 1'b0;
        check("t2_done",  32'(req_done), 32'b001);
        check("t2_vlow",  32'(send_resp_val), 32'd0);
        check("t2_hbusy", 32'(arb_busy), 32'd1);
        req_val = '0;
        tick();
        check("t2_done0", 32'(req_done), 32'd0);
        check("t2_idle",  32'(arb_busy), 32'd0);

        // Reset during BUSY (pointer is now 1); afterwards pointer must be 0.
        req_val = 3'b001;
        tick();
        check("t1_busy", 32'(arb_busy), 32'd1);
        rst_clk_rx_n = 1'b0;
        #1;
        check("t1_val",   32'(send_resp_val),  32'd0);
        check("t1_busy0", 32'(arb_busy),       32'd0);
        check("t1_grant", 32'(arb_grant),      32'd0);
        check("t1_type",  32'(send_resp_type), 32'd0);
        check("t1_data",  32'(send_resp_data), 32'd0);
        check("t1_done",  32'(req_done),       32'd0);
        tick();
        rst_clk_rx_n = 1'b1;
        req_val = 3'b011;
        tick();
        check("t1_grant0", 32'(arb_grant), 32'b001);
        serve(3'b001, 2, 1'b1);
        serve(3'b010, 2, 1'b1);
        tick();

        // Two requesters held continuously: alternation 0,1,0,1.
        do_reset();
        req_val = 3'b011;
        for (int g = 0; g < 4; g++) serve((g % 2 == 1) ? 3'b010 : 3'b001, 12, 1'b0);
        req_val = '0;
        repeat (2) tick();

        // Payload change and val drop mid-BUSY are ignored.
        req_type[1:0] = 2'b01; req_data[15:0] = 16'hBEEF; req_val = 3'b001;
        wait_val();
        check("t4_data", 32'(send_resp_data), 32'hBEEF);
        req_type[1:0] = 2'b00; req_data[15:0] = 16'h0000; req_val = '0;
        repeat (4) tick();
        check("t4_data_hold", 32'(send_resp_data), 32'hBEEF);
        check("t4_type_hold", 32'(send_resp_type), 32'h1);
        check("t4_val_hold",  32'(send_resp_val),  32'd1);
        send_resp_done = 1'b1;
        tick();
        send_resp_done = 1'b0;
        check("t4_done", 32'(req_done), 32'b001);
        tick();

        // Spurious done in IDLE, then in HOLD.
        send_resp_done = 1'b1;
        tick();
        send_resp_done = 1'b0;
        check("t5_idle_done", 32'(req_done), 32'd0);
        check("t5_idle_busy", 32'(arb_busy), 32'd0);
        req_val = 3'b100;
        wait_val();
        send_resp_done = 1'b1;
        tick();
        req_val = '0;
        check("t5_done", 32'(req_done), 32'b100);
        tick();
        send_resp_done = 1'b0;
        check("t5_hold_done", 32'(req_done), 32'd0);
        check("t5_hold_busy", 32'(arb_busy), 32'd0);
        tick();
        check("t5_after_done", 32'(req_done), 32'd0);
        check("t5_after_val",  32'(send_resp_val), 32'd0);

        // Pointer wrap with three requesters.
        do_reset();
        req_val = 3'b010;
        serve(3'b010, 1, 1'b1);   // pointer -> 2
        req_val = 3'b011;
        serve(3'b001, 1, 1'b1);   // wraps to 0, pointer -> 1
        req_val = 3'b110;
        serve(3'b010, 1, 1'b1);
        serve(3'b100, 1, 1'b1);
        repeat (2) tick();

        // Randomized requesters and resp_gen stand-in.
        lat = 2; cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (cyc == 2000) rst_clk_rx_n = 1'b0;
            else if (cyc == 2001) rst_clk_rx_n = 1'b1;
            if (send_resp_val) begin
                if (cnt >= lat) begin
                    send_resp_done = 1'b1; cnt = 0; lat = $urandom_range(0, 6);
                end else begin
                    send_resp_done = 1'b0; cnt++;
                end
            end else begin
                send_resp_done = ($urandom_range(0, 7) == 0);
                cnt = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (req_done[i]) begin
                    req_val[i] = 1'b0;
                end else if (!req_val[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_val[i] = 1'b1;
                        req_type[2*i +: 2]  = 2'($urandom_range(0, 3));
                        req_data[16*i +: 16] = 16'($urandom);
                    end
                end else begin
                    if ($urandom_range(0, 31) == 0) req_val[i] = 1'b0;
                    if ($urandom_range(0, 7) == 0) begin
                        req_type[2*i +: 2]  = 2'($urandom_range(0, 3));
                        req_data[16*i +: 16] = 16'($urandom);
                    end
                end
            end
        end

        // Drain whatever is still in flight.
        req_val = '0;
        for (int c = 0; c < 20; c++) begin
            send_resp_done = send_resp_val;
            tick();
        end
        send_resp_done = 1'b0;
        tick();
        check("final_idle", 32'(arb_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
